uart_rx: RTL

Asynchronous serial receiver. It converts an 8N1 UART line back into parallel bytes. It is the receive-side counterpart of `uart_tx`, with the same framing (start bit 0, DW data bits LSB first, one stop bit 1) and the same `CLK_FREQ`/`BAUD_RATE` derivation, so the two can be looped back directly. It sits between the external `rx` pin and the fabric-side consumer and provides a one-cycle valid pulse per received byte.

---
 rtl/uart_rx.sv | 92 +++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver with mid-bit sampling, glitch reject and framing-error pulse.
module uart_rx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int DW        = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          rx,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  output logic          rx_busy,
  output logic          rx_frame_err
);
  localparam int BAUD_PERIOD = CLK_FREQ / BAUD_RATE;
  localparam int HALF        = BAUD_PERIOD / 2;
  localparam int CW          = $clog2(BAUD_PERIOD);
  localparam int IW          = DW > 1 ? $clog2(DW) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] sh_q, sh_d, data_q, data_d;
  logic          valid_q, valid_d, ferr_q, ferr_d;
  logic          sync_q, rx_s, rx_q;
  logic          fall;
  assign fall         = rx_q & ~rx_s;
  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;
  assign rx_busy      = state_q != IDLE;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= 1'b1;
      rx_s    <= 1'b1;
      rx_q    <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= rx;
      rx_s    <= sync_q;
      rx_q    <= rx_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end
  // Counter restarts from zero on every state entry so each state measures from its own reference point.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = fall ? START : IDLE;
      end
      START: if (cnt_q == CW'(HALF - 1)) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt_q == CW'(BAUD_PERIOD - 1)) begin
        cnt_d   = '0;
        sh_d    = {rx_s, sh_q[DW-1:1]};
        idx_d   = idx_q + 1'b1;
        state_d = idx_q == IW'(DW - 1) ? STOP : DATA;
      end
      STOP: if (cnt_q == CW'(BAUD_PERIOD - 1)) begin
        cnt_d   = '0;
        state_d = IDLE;
        valid_d = rx_s;
        ferr_d  = ~rx_s;
        data_d  = rx_s ? sh_q : data_q;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
